seq_pattern_gen: RTL and testbench



---
 rtl/seq_pattern_gen_pkg.sv | 21 ++
 rtl/seq_pattern_gen_if.sv | 13 +
 rtl/seq_pattern_gen.sv | 104 ++++++++++
 tb/tb_seq_pattern_gen.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/seq_pattern_gen_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// Provides the FSM state encoding and the prefix/suffix overlap helper.
package seq_pattern_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_FIN} state_t;

  localparam int         DEF_PAT_W   = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;

  // Longest proper prefix of pat[w-1:0] that is also a suffix; 0 if none.
  function automatic int calc_ovl(input logic [31:0] pat, input int w);
    int ovl;
    ovl = 0;
    for (int k = w - 1; k >= 1; k--) begin
      if (ovl == 0 && (pat >> (w - k)) == (pat & ((32'd1 << k) - 32'd1)))
        ovl = k;
    end
    return ovl;
  endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Request/serial-output bundle between a burst requester and seq_pattern_gen.
interface seq_pattern_gen_if #(parameter int CNT_W = 8);
  logic             start;
  logic [CNT_W-1:0] count;
  logic             abort;
  logic             out_bit;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (output start, count, abort, input out_bit, out_valid, busy, done);
  modport slave  (input start, count, abort, output out_bit, out_valid, busy, done);
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends PATTERN MSB first, count times, with GAP idle cycles.
// SEQ_PATTERN_GEN_OVERLAP_EN: later repeats skip the self-overlapping prefix and GAP is forced to 0.
module seq_pattern_gen
  import seq_pattern_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int               CNT_W   = 8,
  parameter int               GAP     = 0
) (
  input  logic              clk,
  input  logic              reset,
  seq_pattern_gen_if.slave  bus
);

`ifdef SEQ_PATTERN_GEN_OVERLAP_EN
  localparam int OVL   = calc_ovl(32'(PATTERN), PAT_W);
  localparam int GAP_E = 0;
`else
  localparam int OVL   = 0;
  localparam int GAP_E = GAP;
`endif

  localparam int               IDX_W   = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0] IDX_RLD = IDX_W'(PAT_W - 1 - OVL);
  localparam int               GAP_W   = (GAP_E > 1) ? $clog2(GAP_E) : 1;
  localparam logic [GAP_W-1:0] GAP_LD  = GAP_W'((GAP_E > 0) ? GAP_E - 1 : 0);

  state_t           state;
  logic [IDX_W-1:0] idx;   // index of the bit currently on out_bit
  logic [CNT_W-1:0] rep;   // repeats remaining, including the one in flight
  logic [GAP_W-1:0] gcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      idx           <= '0;
      rep           <= '0;
      gcnt          <= '0;
      bus.out_bit   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.out_bit   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.done      <= 1'b0;
      if (bus.abort && state != ST_IDLE) begin
        state    <= ST_IDLE;
        bus.busy <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (bus.start) begin
            if (bus.count != '0) begin
              state         <= ST_SEND;
              rep           <= bus.count;
              idx           <= IDX_TOP;
              bus.out_bit   <= PATTERN[IDX_TOP];
              bus.out_valid <= 1'b1;
              bus.busy      <= 1'b1;
            end else begin
              state    <= ST_FIN;
              bus.done <= 1'b1;
            end
          end
          ST_SEND: begin
            if (idx != '0) begin
              idx           <= idx - 1'b1;
              bus.out_bit   <= PATTERN[idx - 1'b1];
              bus.out_valid <= 1'b1;
            end else if (rep == CNT_W'(1)) begin
              state    <= ST_FIN;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              rep <= rep - CNT_W'(1);
              if (GAP_E > 0) begin
                state <= ST_GAP;
                gcnt  <= GAP_LD;
              end else begin
                idx           <= IDX_RLD;
                bus.out_bit   <= PATTERN[IDX_RLD];
                bus.out_valid <= 1'b1;
              end
            end
          end
          ST_GAP: begin
            if (gcnt == '0) begin
              state         <= ST_SEND;
              idx           <= IDX_RLD;
              bus.out_bit   <= PATTERN[IDX_RLD];
              bus.out_valid <= 1'b1;
            end else begin
              gcnt <= gcnt - 1'b1;
            end
          end
          default: state <= ST_IDLE;  // FIN: done already registered on entry
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen with a valid-gated 1011 loopback detector model.
module tb_seq_pattern_gen;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_pattern_gen_if #(.CNT_W(8)) bus0 ();
  seq_pattern_gen_if #(.CNT_W(8)) bus2 ();

  seq_pattern_gen #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8), .GAP(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  seq_pattern_gen #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8), .GAP(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2));

  int   n_chk = 0;
  int   n_fail = 0;
  logic g2 = 1'b0;

  wire m_bit   = g2 ? bus2.out_bit   : bus0.out_bit;
  wire m_valid = g2 ? bus2.out_valid : bus0.out_valid;
  wire m_busy  = g2 ? bus2.busy      : bus0.busy;
  wire m_done  = g2 ? bus2.done      : bus0.done;

  // Loopback detector: counts overlapping 1011 matches across valid bits.
  logic [2:0] hist;
  int         det_cnt;
  logic       det_clr = 1'b1;
  always @(negedge clk) begin
    if (det_clr) begin
      hist    <= '0;
      det_cnt <= 0;
    end else if (m_valid) begin
      hist <= {hist[1:0], m_bit};
      if ({hist, m_bit} == 4'b1011) det_cnt <= det_cnt + 1;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input int c);
    if (g2) begin bus2.start = s; bus2.count = 8'(c); end
    else    begin bus0.start = s; bus0.count = 8'(c); end
  endtask

  task automatic run_burst(input logic sel2, input int cnt, input int len,
                           input int rek, input int rec,
                           output logic [63:0] bits, output int nb, output logic [63:0] vm,
                           output int busy_n, output int done_n, output int done_k,
                           output int first_k, output int done_busy);
    g2 = sel2;
    bits = '0; nb = 0; vm = '0; busy_n = 0; done_n = 0; done_k = 0; first_k = 0; done_busy = 0;
    det_clr = 1'b1;
    @(negedge clk); #2 det_clr = 1'b0;
    @(negedge clk); drive(1'b1, cnt);
    for (int k = 1; k <= len + 3; k++) begin
      @(posedge clk); #1;
      vm = {vm[62:0], m_valid};
      if (m_valid) begin
        bits = {bits[62:0], m_bit};
        nb++;
        if (first_k == 0) first_k = k;
      end
      if (m_busy) busy_n++;
      if (m_done) begin done_n++; done_k = k; if (m_busy) done_busy++; end
      @(negedge clk);
      if (k == rek) drive(1'b1, rec); else drive(1'b0, cnt);
    end
  endtask

  typedef struct {
    int          cnt;
    int          nbits;
    logic [63:0] bits;
    int          dets;
  } vec_t;

  vec_t        tbl[4];
  logic [63:0] r_bits, r_vm;
  int          r_nb, r_busy, r_done, r_dk, r_fk, r_db;

  task automatic check_std(input string tag, input vec_t v);
    chk({tag, "_nbits"}, r_nb, v.nbits);
    chk({tag, "_bits"}, r_bits, v.bits);
    chk({tag, "_vmask"}, r_vm, ((64'd1 << v.nbits) - 64'd1) << 3);
    chk({tag, "_first"}, r_fk, (v.nbits != 0) ? 1 : 0);
    chk({tag, "_busy"}, r_busy, v.nbits);
    chk({tag, "_done_n"}, r_done, 1);
    chk({tag, "_done_k"}, r_dk, v.nbits + 1);
    chk({tag, "_done_busy"}, r_db, 0);
    chk({tag, "_det"}, det_cnt, v.dets);
  endtask

  initial begin
`ifdef SEQ_PATTERN_GEN_OVERLAP_EN
    tbl[0] = '{cnt: 1, nbits: 4,  bits: 64'b1011,       dets: 1};
    tbl[1] = '{cnt: 2, nbits: 7,  bits: 64'b1011011,    dets: 2};
    tbl[2] = '{cnt: 0, nbits: 0,  bits: 64'b0,          dets: 0};
    tbl[3] = '{cnt: 3, nbits: 10, bits: 64'b1011011011, dets: 3};
`else
    tbl[0] = '{cnt: 1, nbits: 4,  bits: 64'b1011,         dets: 1};
    tbl[1] = '{cnt: 2, nbits: 8,  bits: 64'b10111011,     dets: 2};
    tbl[2] = '{cnt: 0, nbits: 0,  bits: 64'b0,            dets: 0};
    tbl[3] = '{cnt: 3, nbits: 12, bits: 64'b101110111011, dets: 3};
`endif
    reset = 1'b1;
    bus0.start = 1'b0; bus0.count = '0; bus0.abort = 1'b0;
    bus2.start = 1'b0; bus2.count = '0; bus2.abort = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_out0", {bus0.out_bit, bus0.out_valid, bus0.busy, bus0.done}, 0);
    chk("reset_out2", {bus2.out_bit, bus2.out_valid, bus2.busy, bus2.done}, 0);
    @(negedge clk); reset = 1'b0;

    foreach (tbl[i]) begin
      run_burst(1'b0, tbl[i].cnt, tbl[i].nbits, 0, 0,
                r_bits, r_nb, r_vm, r_busy, r_done, r_dk, r_fk, r_db);
      check_std($sformatf("vec%0d", i), tbl[i]);
    end

`ifndef SEQ_PATTERN_GEN_OVERLAP_EN
    // GAP=2, count=3: 1011 xx 1011 xx 1011
    run_burst(1'b1, 3, 16, 0, 0, r_bits, r_nb, r_vm, r_busy, r_done, r_dk, r_fk, r_db);
    chk("gap_nbits", r_nb, 12);
    chk("gap_bits", r_bits, 64'b101110111011);
    chk("gap_vmask", r_vm, 64'hF3CF << 3);
    chk("gap_busy", r_busy, 16);
    chk("gap_done_n", r_done, 1);
    chk("gap_done_k", r_dk, 17);
    chk("gap_det", det_cnt, 3);
`endif

    // start while busy with count=5 must not change the latched count=2
    run_burst(1'b0, 2, tbl[1].nbits, 2, 5, r_bits, r_nb, r_vm, r_busy, r_done, r_dk, r_fk, r_db);
    check_std("restart", tbl[1]);

    // abort during 2nd bit of the first repeat
    g2 = 1'b0;
    @(negedge clk); bus0.start = 1'b1; bus0.count = 8'd2;
    @(posedge clk); #1;
    chk("abort_bit1", {bus0.out_valid, bus0.out_bit}, 2'b11);
    @(negedge clk); bus0.start = 1'b0;
    @(posedge clk); #1;
    chk("abort_bit2", {bus0.out_valid, bus0.out_bit}, 2'b10);
    @(negedge clk); bus0.abort = 1'b1;
    @(posedge clk); #1;
    chk("abort_out", {bus0.out_valid, bus0.busy, bus0.done}, 0);
    @(negedge clk); bus0.abort = 1'b0;
    @(posedge clk); #1;
    chk("abort_nodone", {bus0.out_valid, bus0.busy, bus0.done}, 0);
    run_burst(1'b0, 1, 4, 0, 0, r_bits, r_nb, r_vm, r_busy, r_done, r_dk, r_fk, r_db);
    check_std("post_abort", tbl[0]);

    // reset mid-burst
    @(negedge clk); bus0.start = 1'b1; bus0.count = 8'd2;
    @(negedge clk); bus0.start = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out", {bus0.out_bit, bus0.out_valid, bus0.busy, bus0.done}, 0);
    @(negedge clk); reset = 1'b0;
    r_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus0.done || bus0.out_valid || bus0.busy) r_done++;
    end
    chk("midrst_quiet", r_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
